// File: rtl/mem_arbiter_if.sv
// Bundle between the arbiter, its two requesters (fetch I, load/store D) and the shared memory.
// slave = arbiter side; master = requesters plus the memory that returns mem_rd.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_done;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic          d_byte;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          d_err;

  logic          mem_we;
  logic          mem_byte_src;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_rd,
    output i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata, d_err,
           mem_we, mem_byte_src, mem_a, mem_wd
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_rd,
    input  i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata, d_err,
           mem_we, mem_byte_src, mem_a, mem_wd
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/load-store arbiter in front of a single-ported memory: gnt -> one ACCESS cycle -> done pulse (2 cycles gnt to done).
// Losing requester waits with req held; MEM_ARB_RR_EN selects round-robin instead of fixed D-over-I priority.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  logic   own_d;
  logic   lat_err;
  logic   arb_ok;
  logic   d_mis;
  logic   pick_d;
  logic   pick_i;
`ifdef MEM_ARB_RR_EN
  logic   last_d;
`endif

  always_comb begin
    arb_ok = reset_n && (state != ACCESS);
    d_mis  = !bus.d_byte && (bus.d_addr[1:0] != 2'b00);
`ifdef MEM_ARB_RR_EN
    pick_d = bus.d_req && !(bus.i_req && last_d);
`else
    pick_d = bus.d_req;
`endif
    pick_i = bus.i_req && !pick_d;
  end

  // gnt is shown in the arbitration cycle so the requester can drop req at the accepting edge.
  assign bus.i_gnt = arb_ok && pick_i;
  assign bus.d_gnt = arb_ok && pick_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      own_d            <= 1'b0;
      lat_err          <= 1'b0;
      bus.i_done       <= 1'b0;
      bus.i_rdata      <= '0;
      bus.d_done       <= 1'b0;
      bus.d_err        <= 1'b0;
      bus.d_rdata      <= '0;
      bus.mem_we       <= 1'b0;
      bus.mem_byte_src <= 1'b0;
      bus.mem_a        <= '0;
      bus.mem_wd       <= '0;
`ifdef MEM_ARB_RR_EN
      last_d           <= 1'b1;
`endif
    end else begin
      bus.i_done <= 1'b0;
      bus.d_done <= 1'b0;
      bus.d_err  <= 1'b0;
      bus.mem_we <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (pick_d) begin
            state            <= ACCESS;
            own_d            <= 1'b1;
            lat_err          <= d_mis;
            bus.mem_we       <= bus.d_we && !d_mis;
            bus.mem_byte_src <= bus.d_byte;
            bus.mem_a        <= bus.d_addr;
            bus.mem_wd       <= bus.d_wdata;
`ifdef MEM_ARB_RR_EN
            last_d           <= 1'b1;
`endif
          end else if (pick_i) begin
            state            <= ACCESS;
            own_d            <= 1'b0;
            lat_err          <= 1'b0;
            bus.mem_byte_src <= 1'b0;
            bus.mem_a        <= bus.i_addr & ~AW'(3);
`ifdef MEM_ARB_RR_EN
            last_d           <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state <= RESP;
          // A misaligned word access never wrote and returns zero data with the error flag.
          if (own_d) begin
            bus.d_done  <= 1'b1;
            bus.d_err   <= lat_err;
            bus.d_rdata <= lat_err ? {DW{1'b0}} : bus.mem_rd;
          end else begin
            bus.i_done  <= 1'b1;
            bus.i_rdata <= bus.mem_rd;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-array memory, transaction-level reference model, per-cycle compare and directed tests.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();
  mem_arbiter #(.AW(32), .DW(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  // Memory under the arbiter: little-endian bytes, combinational read, write at the clock edge.
  logic [7:0] mem [64];
  logic [5:0] wb;
  assign wb = {bus.mem_a[5:2], 2'b00};
  assign bus.mem_rd = bus.mem_byte_src ? {24'h0, mem[bus.mem_a[5:0]]}
                                       : {mem[wb + 6'd3], mem[wb + 6'd2], mem[wb + 6'd1], mem[wb]};
  always @(posedge clk)
    if (bus.mem_we) begin
      if (bus.mem_byte_src) mem[bus.mem_a[5:0]] <= bus.mem_wd[7:0];
      else for (int k = 0; k < 4; k++) mem[wb + 6'(k)] <= bus.mem_wd[8*k +: 8];
    end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  rm [64];
  logic        m_acc = 1'b0;
  logic        m_last_d = 1'b1;
  logic        p_d = 1'b0, p_we = 1'b0, p_byte = 1'b0, p_err = 1'b0;
  logic [31:0] p_addr = '0, p_wd = '0;
  logic        e_i_done = 1'b0, e_d_done = 1'b0, e_d_err = 1'b0, e_we = 1'b0, e_bs = 1'b0;
  logic [31:0] e_a = '0, e_wd = '0, e_i_rdata = '0, e_d_rdata = '0;
  logic [31:0] rv;
  int          who;

  // 0 = nobody, 1 = port I, 2 = port D
  function automatic int pick(input logic ir, input logic dr, input logic lastd);
`ifdef MEM_ARB_RR_EN
    if (ir && dr) return lastd ? 1 : 2;
`endif
    if (dr) return 2;
    if (ir) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] rm_read(input logic [31:0] a, input logic byt);
    logic [5:0] b;
    b = {a[5:2], 2'b00};
    if (byt) return {24'h0, rm[a[5:0]]};
    return {rm[b + 6'd3], rm[b + 6'd2], rm[b + 6'd1], rm[b]};
  endfunction

  task automatic rm_write(input logic [31:0] a, input logic byt, input logic [31:0] d);
    if (byt) rm[a[5:0]] = d[7:0];
    else for (int k = 0; k < 4; k++) rm[{a[5:2], 2'b00} + 6'(k)] = d[8*k +: 8];
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_acc = 1'b0; m_last_d = 1'b1;
      e_i_done = 1'b0; e_d_done = 1'b0; e_d_err = 1'b0; e_we = 1'b0; e_bs = 1'b0;
      e_a = '0; e_wd = '0; e_i_rdata = '0; e_d_rdata = '0;
    end else begin
      e_i_done = 1'b0; e_d_done = 1'b0; e_d_err = 1'b0; e_we = 1'b0;
      if (m_acc) begin
        m_acc = 1'b0;
        rv = p_err ? 32'h0 : rm_read(p_addr, p_byte);
        if (p_d) begin
          e_d_done = 1'b1; e_d_err = p_err; e_d_rdata = rv;
          if (p_we && !p_err) rm_write(p_addr, p_byte, p_wd);
        end else begin
          e_i_done = 1'b1; e_i_rdata = rv;
        end
      end else begin
        who = pick(bus.i_req, bus.d_req, m_last_d);
        if (who != 0) begin
          m_acc = 1'b1; m_last_d = (who == 2); p_d = (who == 2);
        end
        if (who == 2) begin
          p_we = bus.d_we; p_byte = bus.d_byte; p_addr = bus.d_addr; p_wd = bus.d_wdata;
          p_err = !bus.d_byte && (bus.d_addr[1:0] != 2'b00);
          e_we = p_we && !p_err; e_bs = p_byte; e_a = p_addr; e_wd = p_wd;
        end else if (who == 1) begin
          p_we = 1'b0; p_byte = 1'b0; p_err = 1'b0; p_addr = {bus.i_addr[31:2], 2'b00};
          e_bs = 1'b0; e_a = p_addr;
        end
      end
    end
  end

  int   who_c;
  logic arb;
  int   we_cnt = 0;
  int   done_cnt = 0;

  always @(negedge clk) begin
    who_c = pick(bus.i_req, bus.d_req, m_last_d);
    arb   = reset_n && !m_acc;
    chk1("i_gnt", bus.i_gnt, arb && who_c == 1);
    chk1("d_gnt", bus.d_gnt, arb && who_c == 2);
    chk1("i_done", bus.i_done, e_i_done);
    chk1("d_done", bus.d_done, e_d_done);
    chk1("d_err", bus.d_err, e_d_err);
    chk1("mem_we", bus.mem_we, e_we);
    chk1("mem_byte_src", bus.mem_byte_src, e_bs);
    chk("mem_a", bus.mem_a, e_a);
    chk("mem_wd", bus.mem_wd, e_wd);
    chk("i_rdata", bus.i_rdata, e_i_rdata);
    chk("d_rdata", bus.d_rdata, e_d_rdata);
    if (bus.mem_we === 1'b1) we_cnt++;
    if (bus.d_done === 1'b1) done_cnt++;
  end

  // ---------------- stimulus ----------------
  // Called at posedge+2; returns at posedge+2 of the cycle after done.
  task automatic op(input logic is_d, input logic we, input logic byt, input logic [31:0] addr,
                    input logic [31:0] wd, output logic [31:0] rd, output logic err,
                    output int gw, output int dw);
    logic g;
    logic dn;
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_byte = byt; bus.d_addr = addr; bus.d_wdata = wd;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = addr;
    end
    g = 1'b0; gw = 0;
    while (!g && gw < 20) begin
      @(negedge clk);
      gw++;
      g = is_d ? bus.d_gnt : bus.i_gnt;
    end
    @(posedge clk); #2;
    if (is_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
    if (!g) begin
      n_chk++; n_fail++;
      $display("FAIL gnt_timeout: no grant within 20 cycles, required a grant");
    end
    dn = 1'b0; dw = 0;
    while (!dn && dw < 20) begin
      @(negedge clk);
      dw++;
      dn = is_d ? bus.d_done : bus.i_done;
    end
    rd  = is_d ? bus.d_rdata : bus.i_rdata;
    err = bus.d_err;
    if (!dn) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: no done within 20 cycles, required a done");
    end
    @(posedge clk); #2;
  endtask

  logic [31:0] init_w [16];
  logic [31:0] rd;
  logic        er;
  int          gw, dw, w0, d0, ic, dc, ov;
  logic [3:0]  seq;

  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_byte = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    for (int i = 0; i < 16; i++) init_w[i] = 32'h0;
    init_w[0] = 32'hE3A01005;
    init_w[1] = 32'h11223344;
    init_w[3] = 32'hCAFEF00D;
    for (int i = 0; i < 16; i++)
      for (int b = 0; b < 4; b++) begin
        mem[4*i + b] <= init_w[i][8*b +: 8];
        rm[4*i + b]   = init_w[i][8*b +: 8];
      end

    #1 reset_n = 1'b0;
    @(posedge clk); #2;
    chk1("reset_mem_we", bus.mem_we, 1'b0);
    chk1("reset_i_done", bus.i_done, 1'b0);
    chk("reset_d_rdata", bus.d_rdata, 32'h0);
    @(posedge clk); #2;
    reset_n = 1'b1;

    // fetch of word 0
    op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rd, er, gw, dw);
    chk("fetch_rdata", rd, 32'hE3A01005);
    chk("fetch_gnt_cycle", gw, 1);
    chk("fetch_gnt_to_done", dw, 2);

    // word store then load
    w0 = we_cnt;
    op(1'b1, 1'b1, 1'b0, 32'h8, 32'hFFFFFFFF, rd, er, gw, dw);
    chk("st_we_cycles", we_cnt - w0, 1);
    chk1("st_err", er, 1'b0);
    op(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, rd, er, gw, dw);
    chk("ld_word8", rd, 32'hFFFFFFFF);

    // byte store then word/byte loads
    w0 = we_cnt;
    op(1'b1, 1'b1, 1'b1, 32'h9, 32'h00000085, rd, er, gw, dw);
    chk("stb_we_cycles", we_cnt - w0, 1);
    op(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, rd, er, gw, dw);
    chk("ld_word8_after_byte", rd, 32'hFFFF85FF);
    op(1'b1, 1'b0, 1'b1, 32'h9, 32'h0, rd, er, gw, dw);
    chk("ldb_9", rd, 32'h00000085);

    // contention: both requesting for 8 cycles, last grant was D
    bus.i_addr = 32'h4; bus.d_we = 1'b0; bus.d_byte = 1'b0; bus.d_addr = 32'h8;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    ic = 0; dc = 0; ov = 0; seq = 4'h0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.i_gnt && bus.d_gnt) ov++;
      if (bus.i_gnt) begin ic++; seq = {seq[2:0], 1'b0}; end
      if (bus.d_gnt) begin dc++; seq = {seq[2:0], 1'b1}; end
      @(posedge clk); #2;
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
`ifdef MEM_ARB_RR_EN
    chk("rr_i_gnts", ic, 2);
    chk("rr_d_gnts", dc, 2);
    chk("rr_order_IDID", {28'h0, seq}, 32'h5);
`else
    chk("fp_d_gnts", dc, 4);
    chk("fp_i_gnts", ic, 0);
`endif
    chk("gnt_overlap", ov, 0);

    // misaligned word store
    w0 = we_cnt;
    op(1'b1, 1'b1, 1'b0, 32'h6, 32'hDEADBEEF, rd, er, gw, dw);
    chk("mis_we_cycles", we_cnt - w0, 0);
    chk1("mis_err", er, 1'b1);
    chk("mis_rdata", rd, 32'h0);
    op(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, rd, er, gw, dw);
    chk("mis_word4_unchanged", rd, 32'h11223344);

    // misaligned fetch is word-aligned
    op(1'b0, 1'b0, 1'b0, 32'h2, 32'h0, rd, er, gw, dw);
    chk("misfetch_rdata", rd, 32'hE3A01005);

    // reset during the ACCESS cycle of a store
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_byte = 1'b0; bus.d_addr = 32'hC; bus.d_wdata = 32'h12345678;
    gw = 0;
    do begin @(negedge clk); gw++; end while (!bus.d_gnt && gw < 20);
    @(posedge clk); #2;
    bus.d_req = 1'b0;
    chk1("rst_access_we", bus.mem_we, 1'b1);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    chk1("rst_we_drop", bus.mem_we, 1'b0);
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (2) begin @(posedge clk); #2; end
    chk("rst_no_done", done_cnt - d0, 0);
    op(1'b1, 1'b0, 1'b0, 32'hC, 32'h0, rd, er, gw, dw);
    chk("rst_wordC_unchanged", rd, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: summary not reached within time limit");
    $fatal(1);
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-ported unified memory (`mem`: clk, we, byte_src, a, wd, rd).
- Port I: read-only instruction fetch.
- Port D: load/store, word or byte.
- The block latches one request and drives the memory for exactly one ACCESS cycle.
- It returns read data with a one-cycle done pulse, so fetch and load/store can share one memory.

Parameters:
AW, 32, address width (byte address, passed unchanged to mem.a)
DW, 32, data width (mem.wd / mem.rd)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held until i_gnt
i_addr  in  AW  fetch byte address
i_gnt  out  1  one-cycle pulse: fetch request accepted and latched
i_done  out  1  one-cycle pulse: i_rdata valid
i_rdata  out  DW  fetched word
d_req  in  1  data request; held until d_gnt
d_we  in  1  1 = store, 0 = load
d_byte  in  1  1 = byte access, 0 = word access (drives mem byte_src)
d_addr  in  AW  data byte address
d_wdata  in  DW  store data (byte store uses bits [7:0])
d_gnt  out  1  one-cycle pulse: data request accepted
d_done  out  1  one-cycle pulse: access complete, d_rdata/d_err valid
d_rdata  out  DW  load data (byte load: zero-extended by mem)
d_err  out  1  valid with d_done: misaligned word access
mem_we  out  1  memory write enable
mem_byte_src  out  1  memory byte select
mem_a  out  AW  memory address
mem_wd  out  DW  memory write data
mem_rd  in  DW  memory read data (combinational from mem_a)

Behaviour:
- Reset (async, reset_n=0): state=IDLE.
  - All outputs 0; latched request cleared; last-grant pointer = D.
  - mem_we drops immediately, without waiting for a clock.
- States:
  - IDLE: no access in flight.
  - ACCESS: memory driven.
  - RESP: done pulse asserted.
- Arbitration happens at rising edges in IDLE or RESP:
  - If any req is asserted, select one port, pulse its gnt for one cycle, latch that port's addr/we/byte/wdata, and go to ACCESS.
  - If no req is asserted, go (or stay) in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_a, mem_byte_src and mem_wd come from the latch.
  - mem_we = latched we; mem_we is 1 only in ACCESS.
  - Store commits at the edge ending ACCESS.
  - mem_rd is captured into i_rdata or d_rdata at that same edge.
  - Next state: RESP.
- RESP (1 cycle): the owning port's done pulses. A new grant may be issued at the edge ending RESP.
- Timing:
  - Latency is 2 cycles from gnt to done.
  - Peak throughput is one access every 2 cycles.
- Port I is always a word read: mem_byte_src=0, mem_we=0.
- Outside ACCESS, mem_a, mem_wd and mem_byte_src hold their last values; mem_we=0.
- Misaligned access: d_byte=0 with d_addr[1:0]≠0 is granted normally, then:
  - ACCESS runs with mem_we forced 0.
  - d_done is asserted with d_err=1 and d_rdata=0.
- Misaligned fetch (i_addr[1:0]≠0): the address is forced word-aligned by clearing bits [1:0]; no error is reported.
- Simultaneous i_req and d_req: D wins (fixed priority; see Optional Feature).
- The unselected request stays pending; its requester must keep req high. No gnt is issued while in ACCESS.
- rdata holds its value until the next done for that port.
- d_err is valid only with d_done and is 0 otherwise.
- Reset mid-ACCESS:
  - The store is not committed.
  - No done is issued.
  - Requesters must re-issue after reset.

Optional Feature:
Macro: MEM_ARB_RR_EN
- Defined: round-robin arbitration.
  - On a simultaneous request, the port not granted last wins.
  - The pointer updates on every grant.
  - With both requesting continuously, grants alternate I, D, I, D.
- Undefined: fixed priority, D over I; the pointer logic is absent. I can starve under continuous d_req.

Test Plan:
- Fetch read: mem preloaded word0=0xE3A01005; i_req=1, i_addr=0x0 → i_gnt at cycle 1, mem_we=0 throughout, i_done at cycle 3 with i_rdata=0xE3A01005.
- Word store then load: d_req, d_we=1, d_byte=0, d_addr=0x8, d_wdata=0xFFFFFFFF → mem_we=1 for exactly one cycle, d_done with d_err=0. Then load 0x8 → d_rdata=0xFFFFFFFF.
- Byte store/load: store d_byte=1, d_addr=0x9, d_wdata=0x85 → load word 0x8 reads 0xFFFF85FF (little-endian); byte load 0x9 → d_rdata=0x00000085.
- Contention: i_req and d_req both held high for 8 cycles.
  - Without MEM_ARB_RR_EN: 4 d_gnt, 0 i_gnt.
  - With MEM_ARB_RR_EN: grant order I, D, I, D; gnt pulses never overlap.
- Misaligned store: d_byte=0, d_addr=0x6, d_we=1 → mem_we stays 0, d_done=1 with d_err=1 and d_rdata=0; a subsequent load from 0x4 shows the word unchanged.
- Reset mid-ACCESS: assert reset_n=0 during the ACCESS cycle of a store → mem_we drops the same cycle, no d_done, target word unchanged, all outputs 0; after release, a new d_req is serviced normally.
